riscv_ex_result_pipe: RTL and testbench

Execute-to-writeback result stage. It sits directly downstream of the RV32I ALU and consumes its `result_o` and `comparison_result_o`, plus the decoder's destination and branch metadata. It registers that data into a 2-entry elastic buffer with valid/ready handshakes on both sides. It also resolves conditional branches into a registered one-cycle redirect pulse.

---
 rtl/riscv_ex_result_pipe.sv | 179 +++++++++++++++++
 tb/tb_riscv_ex_result_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ex_result_pipe.sv
// ----------------------------------------------------------------------------
// riscv_ex_result_pipe
//   Execute-to-writeback result stage. ALU results and decoder metadata are
//   captured into a 2-entry elastic buffer (head + skid) with valid/ready on
//   both sides. Conditional branches are resolved when accepted and produce a
//   registered one-cycle redirect pulse.
//
//   Optional feature: define RISCV_EX_PIPE_STALL_CNT_EN to add stall_cnt_o, a
//   saturating count of cycles with ex_valid_i & ~ex_ready_o.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush_i               drop all buffered entries and any same-cycle accept
//   ex_valid_i/ex_ready_o upstream handshake
//   alu_result_i          ALU result (XLEN)
//   cmp_result_i          ALU comparison result (branch taken when set)
//   rd_addr_i, rd_we_i    destination register and write request
//   is_branch_i           conditional branch marker
//   branch_target_i       precomputed branch target
//   wb_valid_o/wb_ready_i downstream handshake
//   wb_data_o, wb_rd_addr_o, wb_rd_we_o  head entry fields
//   branch_taken_o        one-cycle redirect pulse
//   branch_target_o       redirect PC, meaningful while branch_taken_o=1
//   stall_cnt_o           (optional) upstream stall cycle counter
// ----------------------------------------------------------------------------
module riscv_ex_result_pipe #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            cmp_result_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_we_i,
    input  logic            is_branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic            wb_rd_we_o,
    output logic            branch_taken_o,
    output logic [XLEN-1:0] branch_target_o
`ifdef RISCV_EX_PIPE_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt_o
`endif
);

    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [REG_W-1:0] rd_addr;
        logic             we;
    } entry_t;

    // Encoding equals buffer occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    entry_t          head_q, head_d;
    entry_t          skid_q, skid_d;
    entry_t          in_entry;
    logic            ready_q;
    logic            valid_q;
    logic            taken_q, taken_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            accept;
    logic            pop;

    // Handshake decode; ready/valid come from flops, so no ready-to-ready path.
    assign accept = ex_valid_i & ready_q & ~flush_i;
    assign pop    = valid_q & wb_ready_i;

    // Branches and x0 writes never reach the register file.
    assign in_entry.data    = alu_result_i;
    assign in_entry.rd_addr = rd_addr_i;
    assign in_entry.we      = rd_we_i & ~is_branch_i & (rd_addr_i != REG_W'(0));

    // Next-state, slot updates and branch pulse.
    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        skid_d   = skid_q;
        taken_d  = accept & is_branch_i & cmp_result_i;
        target_d = target_q;

        if (taken_d) begin
            target_d = branch_target_i;
        end

        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        head_d  = in_entry;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        state_d = FULL;
                        skid_d  = in_entry;
                    end else if (accept && pop) begin
                        head_d  = in_entry;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        head_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State, slots and registered handshake/pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            head_q   <= '0;
            skid_q   <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            skid_q   <= skid_d;
            ready_q  <= (state_d != FULL);
            valid_q  <= (state_d != EMPTY);
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    assign ex_ready_o      = ready_q;
    assign wb_valid_o      = valid_q;
    assign wb_data_o       = head_q.data;
    assign wb_rd_addr_o    = head_q.rd_addr;
    assign wb_rd_we_o      = head_q.we;
    assign branch_taken_o  = taken_q;
    assign branch_target_o = target_q;

`ifdef RISCV_EX_PIPE_STALL_CNT_EN
    localparam int unsigned STALL_W = 32;

    logic [STALL_W-1:0] stall_cnt_q;

    // Saturating upstream stall counter; flush does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (ex_valid_i && !ready_q && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_ex_result_pipe.sv
// ----------------------------------------------------------------------------
// tb_riscv_ex_result_pipe
//   Scoreboard bench. A reference model (capacity-2 FIFO occupancy plus a
//   queue of expected entries) advances on each clock edge; a separate
//   monitor on the falling edge compares the DUT head, handshakes and branch
//   pulse against it. Directed sequences followed by randomized traffic.
// ----------------------------------------------------------------------------
module tb_riscv_ex_result_pipe;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            flush = 1'b0;
    logic            ex_valid = 1'b0;
    logic            ex_ready;
    logic [XLEN-1:0] alu_result = '0;
    logic            cmp_result = 1'b0;
    logic [4:0]      rd_addr = '0;
    logic            rd_we = 1'b0;
    logic            is_branch = 1'b0;
    logic [XLEN-1:0] branch_target = '0;
    logic            wb_valid;
    logic            wb_ready = 1'b0;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      wb_rd_addr;
    logic            wb_rd_we;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target_out;
`ifdef RISCV_EX_PIPE_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    riscv_ex_result_pipe #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush),
        .ex_valid_i      (ex_valid),
        .ex_ready_o      (ex_ready),
        .alu_result_i    (alu_result),
        .cmp_result_i    (cmp_result),
        .rd_addr_i       (rd_addr),
        .rd_we_i         (rd_we),
        .is_branch_i     (is_branch),
        .branch_target_i (branch_target),
        .wb_valid_o      (wb_valid),
        .wb_ready_i      (wb_ready),
        .wb_data_o       (wb_data),
        .wb_rd_addr_o    (wb_rd_addr),
        .wb_rd_we_o      (wb_rd_we),
        .branch_taken_o  (branch_taken),
        .branch_target_o (branch_target_out)
`ifdef RISCV_EX_PIPE_STALL_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t        exp_q[$];
    int          occ = 0;
    logic        exp_taken = 1'b0;
    logic [31:0] exp_target = '0;
    logic [31:0] exp_stall = '0;
    logic        m_pop;
    logic        m_acc;
    exp_t        m_ent;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a 2-deep FIFO that accepts while fewer than two entries
    // are held, pops when non-empty and writeback is ready, and empties on flush.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            occ        = 0;
            exp_q.delete();
            exp_taken  = 1'b0;
            exp_target = '0;
            exp_stall  = '0;
        end else begin
            m_pop = (occ > 0) && wb_ready;
            m_acc = ex_valid && (occ < 2) && !flush;
            if (ex_valid && (occ == 2) && (exp_stall != 32'hFFFF_FFFF)) exp_stall = exp_stall + 32'd1;
            exp_taken = m_acc && is_branch && cmp_result;
            if (exp_taken) exp_target = branch_target;
            if (flush) begin
                occ = 0;
                exp_q.delete();
            end else begin
                if (m_pop) occ = occ - 1;
                if (m_acc) begin
                    occ = occ + 1;
                    m_ent.data = alu_result;
                    m_ent.rd   = rd_addr;
                    m_ent.we   = rd_we && !is_branch && (rd_addr != 5'd0);
                    exp_q.push_back(m_ent);
                end
            end
        end
    end

    // Monitor: compare outputs mid-cycle against the model.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_ex_ready", 64'(ex_ready), 64'(1));
            check("rst_wb_valid", 64'(wb_valid), 64'(0));
            check("rst_wb_data", 64'(wb_data), 64'(0));
            check("rst_wb_rd_addr", 64'(wb_rd_addr), 64'(0));
            check("rst_wb_rd_we", 64'(wb_rd_we), 64'(0));
            check("rst_branch_taken", 64'(branch_taken), 64'(0));
            check("rst_branch_target", 64'(branch_target_out), 64'(0));
`ifdef RISCV_EX_PIPE_STALL_CNT_EN
            check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
        end else begin
            check("ex_ready", 64'(ex_ready), 64'(occ < 2));
            check("wb_valid", 64'(wb_valid), 64'(occ > 0));
            check("branch_taken", 64'(branch_taken), 64'(exp_taken));
            if (exp_taken) check("branch_target", 64'(branch_target_out), 64'(exp_target));
`ifdef RISCV_EX_PIPE_STALL_CNT_EN
            check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got data 0x%0h with no entry expected at %0t", wb_data, $time);
                end else begin
                    check("wb_data", 64'(wb_data), 64'(exp_q[0].data));
                    check("wb_rd_addr", 64'(wb_rd_addr), 64'(exp_q[0].rd));
                    check("wb_rd_we", 64'(wb_rd_we), 64'(exp_q[0].we));
                    if (wb_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic [4:0] rd, input logic we,
                       input logic br, input logic cmp, input logic [31:0] tgt,
                       input logic wbr, input logic fl);
        @(posedge clk);
        #1;
        ex_valid      = v;
        alu_result    = d;
        rd_addr       = rd;
        rd_we         = we;
        is_branch     = br;
        cmp_result    = cmp;
        branch_target = tgt;
        wb_ready      = wbr;
        flush         = fl;
    endtask

    task automatic idle(input int n, input logic wbr);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, wbr, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3, 1'b0);

        // Streaming, writeback always ready.
        cyc(1'b1, 32'h11, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h22, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h33, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h44, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Back-pressure: third entry waits until space frees.
        cyc(1'b1, 32'h11, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h33, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h33, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h33, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h33, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // x0 write suppression, taken and not-taken branches.
        cyc(1'b1, 32'h55, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h66, 5'd7, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
        cyc(1'b1, 32'h77, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Fill, last fill is a taken branch, then flush with a taken branch offered.
        cyc(1'b1, 32'hA1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'hA2, 5'd4, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b0);
        cyc(1'b1, 32'hA3, 5'd6, 1'b1, 1'b1, 1'b1, 32'h0000_0800, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Stall counting from a clean reset, then reset while stalled.
        do_reset();
        cyc(1'b1, 32'hB1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB2, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'hB3, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1, 1'b0);
        do_reset();
        idle(3, 1'b1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)), 1'($urandom),
                    $urandom_range(0, 3) == 0, 1'($urandom), $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            end
        end
        idle(5, 1'b1);
        @(negedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
